// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - request/response and memory bus bundle for dmem_arbiter
// slave is the arbiter's view; master is the requesters' and memory's view.
interface dmem_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req0_ready;
  logic              req0_we;
  logic [DATA_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req1_valid;
  logic              req1_ready;
  logic              req1_we;
  logic [DATA_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              rsp0_valid;
  logic              rsp0_ready;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              write_enable;
  logic              read_enable;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    input  rsp0_ready, rsp1_ready, mem_read_data,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata, rsp_err,
    output write_enable, read_enable, mem_addr, mem_write_data
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    output rsp0_ready, rsp1_ready, mem_read_data,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata, rsp_err,
    input  write_enable, read_enable, mem_addr, mem_write_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-port arbiter for the single-port data memory
// Define DMEM_ARB_ALIGN_CHECK_EN to reject misaligned or out-of-range accesses with rsp_err.
module dmem_arbiter #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state_q;
  logic              last_grant_q;
  logic              owner_q;
  logic              we_q;
  logic              illegal_q;
  logic              wr_en_q;
  logic              rd_en_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic              rsp0_valid_q;
  logic              rsp1_valid_q;

  logic              grant_d;
  logic              accept_d;
  logic              we_d;
  logic              legal_d;
  logic [DATA_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

  // A tie goes to the port that did not win last; a lone requester always wins.
  assign grant_d  = (bus.req0_valid && bus.req1_valid) ? !last_grant_q : bus.req1_valid;
  assign bus.req0_ready = (state_q == IDLE) && bus.req0_valid && !grant_d;
  assign bus.req1_ready = (state_q == IDLE) && bus.req1_valid && grant_d;
  assign accept_d = bus.req0_ready || bus.req1_ready;

  assign we_d    = grant_d ? bus.req1_we    : bus.req0_we;
  assign addr_d  = grant_d ? bus.req1_addr  : bus.req0_addr;
  assign wdata_d = grant_d ? bus.req1_wdata : bus.req0_wdata;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign legal_d = (addr_d[1:0] == 2'b00) && ((addr_d >> 2) < DATA_W'(DEPTH_WORDS));
`else
  logic [31:0] unused_depth;
  assign unused_depth = 32'(DEPTH_WORDS);
  assign legal_d      = 1'b1;
`endif

  // Reset gates the write strobe combinationally so a reset during ISSUE never commits.
  assign bus.write_enable   = wr_en_q && rst_n;
  assign bus.read_enable    = rd_en_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_write_data = wdata_q;
  assign bus.rsp0_valid     = rsp0_valid_q;
  assign bus.rsp1_valid     = rsp1_valid_q;
  assign bus.rsp_rdata      = rsp_rdata_q;
  assign bus.rsp_err        = rsp_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      illegal_q    <= 1'b0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            owner_q      <= grant_d;
            last_grant_q <= grant_d;
            we_q         <= we_d;
            illegal_q    <= !legal_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wr_en_q      <= we_d && legal_d;
            rd_en_q      <= !we_d && legal_d;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          wr_en_q      <= 1'b0;
          rd_en_q      <= 1'b0;
          rsp_rdata_q  <= (we_q || illegal_q) ? '0 : bus.mem_read_data;
          rsp_err_q    <= illegal_q;
          rsp0_valid_q <= !owner_q;
          rsp1_valid_q <= owner_q;
          state_q      <= RESP;
        end
        RESP: begin
          if ((rsp0_valid_q && bus.rsp0_ready) || (rsp1_valid_q && bus.rsp1_ready)) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter
// A transaction-level model predicts every output on each falling edge.
module tb_dmem_arbiter;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_W(DATA_W)) bus ();

  dmem_arbiter #(.DATA_W(DATA_W), .DEPTH_WORDS(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory attached to the DUT: combinational read, write on the rising edge.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  assign bus.mem_read_data = mem[bus.mem_addr[9:2]];
  always @(posedge clk) if (bus.write_enable) mem[bus.mem_addr[9:2]] <= bus.mem_write_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait expired, got no event, required one (cycle %0d)", name, cyc);
  endtask

  function automatic bit legal_f(input logic [DATA_W-1:0] a);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    return (a % 4 == 0) && (a / 4 < DEPTH);
`else
    return 1'b1 || (a == 0);
`endif
  endfunction

  // Reference model: one transaction at a time, stage counted from its accept.
  bit                m_busy  = 1'b0;
  bit                m_last  = 1'b1;
  bit                m_owner, m_we, m_legal, m_err;
  int                m_age;
  logic [DATA_W-1:0] m_addr, m_wdata, m_rdata;
  logic [DATA_W-1:0] m_maddr = '0;
  logic [DATA_W-1:0] m_mwd   = '0;
  logic [DATA_W-1:0] ref_mem [DEPTH] = '{default: '0};
  int                grant_log [$];

  always @(negedge clk) begin
    bit v0, v1, g, e_r0, e_r1, e_we, e_re, e_v0, e_v1;
    v0 = bus.req0_valid;
    v1 = bus.req1_valid;
    g  = (v0 && v1) ? !m_last : v1;
    e_r0 = 0; e_r1 = 0; e_we = 0; e_re = 0; e_v0 = 0; e_v1 = 0;
    if (!m_busy) begin
      e_r0 = v0 && !g;
      e_r1 = v1 && g;
    end else if (m_age == 1) begin
      e_we = m_we && m_legal && rst_n;
      e_re = !m_we && m_legal;
    end else begin
      e_v0 = !m_owner;
      e_v1 = m_owner;
    end
    if (chk_en) begin
      chk("req0_ready", 32'(bus.req0_ready), 32'(e_r0));
      chk("req1_ready", 32'(bus.req1_ready), 32'(e_r1));
      chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(e_v0));
      chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(e_v1));
      chk("write_enable", 32'(bus.write_enable), 32'(e_we));
      chk("read_enable", 32'(bus.read_enable), 32'(e_re));
      chk("mem_addr", bus.mem_addr, m_maddr);
      chk("mem_write_data", bus.mem_write_data, m_mwd);
      if (m_busy && m_age >= 2) begin
        chk("rsp_rdata", bus.rsp_rdata, m_rdata);
        chk("rsp_err", 32'(bus.rsp_err), 32'(m_err));
      end
    end
    if (!rst_n) begin
      m_busy  = 0;
      m_last  = 1;
      m_maddr = '0;
      m_mwd   = '0;
    end else if (!m_busy) begin
      if (e_r0 || e_r1) begin
        m_busy  = 1;
        m_age   = 1;
        m_owner = g;
        m_last  = g;
        m_we    = g ? bus.req1_we : bus.req0_we;
        m_addr  = g ? bus.req1_addr : bus.req0_addr;
        m_wdata = g ? bus.req1_wdata : bus.req0_wdata;
        m_legal = legal_f(m_addr);
        m_maddr = m_addr;
        m_mwd   = m_wdata;
        grant_log.push_back(int'(g));
      end
    end else if (m_age == 1) begin
      m_rdata = (m_we || !m_legal) ? '0 : ref_mem[m_addr[9:2]];
      m_err   = !m_legal;
      if (m_we && m_legal) ref_mem[m_addr[9:2]] = m_wdata;
      m_age = 2;
    end else if (m_owner ? bus.rsp1_ready : bus.rsp0_ready) begin
      m_busy = 0;
    end
  end

  task automatic set_req(input int p, input bit v, input bit we,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] d);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
    end else begin
      bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d;
    end
  endtask

  task automatic set_rsp_ready(input int p, input bit r);
    if (p == 0) bus.rsp0_ready = r;
    else        bus.rsp1_ready = r;
  endtask

  function automatic bit rdy(input int p);
    return (p == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  function automatic bit rspv(input int p);
    return (p == 0) ? bus.rsp0_valid : bus.rsp1_valid;
  endfunction

  function automatic logic [DATA_W-1:0] rand_addr();
    logic [DATA_W-1:0] a;
    a = 32'($urandom_range(0, 63)) << 2;
    if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
    if ($urandom_range(0, 7) == 0) a = a | 32'h400;
    return a;
  endfunction

  // One request on port p; the response is held unconsumed for 'hold' cycles.
  task automatic txn(input int p, input bit we, input logic [DATA_W-1:0] a,
                     input logic [DATA_W-1:0] d, input int hold,
                     output logic [DATA_W-1:0] rdata, output bit err,
                     output int lat, output bit re_issue);
    int n;
    int acc;
    rdata = '0; err = 0; lat = -1; re_issue = 0;
    set_rsp_ready(p, hold == 0);
    set_req(p, 1, we, a, d);
    n = 0;
    @(negedge clk);
    while (!rdy(p) && n < 40) begin @(negedge clk); n++; end
    if (!rdy(p)) begin
      fail_now("accept_timeout");
      set_req(p, 0, 0, '0, '0);
      return;
    end
    acc = cyc;
    @(posedge clk); #1;
    set_req(p, 0, 0, '0, '0);
    @(negedge clk);
    re_issue = bus.read_enable;
    n = 0;
    while (!rspv(p) && n < 40) begin @(negedge clk); n++; end
    if (!rspv(p)) begin
      fail_now("rsp_timeout");
      return;
    end
    lat   = cyc - acc;
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 32'(rspv(p)), 32'd1);
      chk("hold_rdata", bus.rsp_rdata, rdata);
      chk("hold_req0_ready", 32'(bus.req0_ready), 32'd0);
      @(posedge clk); #1;
      if (i == hold - 1) set_rsp_ready(p, 1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    set_rsp_ready(p, 0);
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    bit                er;
    bit                rei;
    int                lat;
    int                n;

    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    bus.rsp0_ready = 0;
    bus.rsp1_ready = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk_en = 1;
    @(negedge clk);
    chk("reset_mem_addr", bus.mem_addr, 32'h0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("reset_rsp_err", 32'(bus.rsp_err), 32'h0);
    @(posedge clk); #1;

    txn(0, 1, 32'h10, 32'hDEADBEEF, 0, rd, er, lat, rei);
    chk("wr_latency", 32'(lat), 32'd2);
    chk("wr_rdata", rd, 32'h0);
    chk("wr_err", 32'(er), 32'h0);
    txn(0, 0, 32'h10, 32'h0, 0, rd, er, lat, rei);
    chk("rd_latency", 32'(lat), 32'd2);
    chk("rd_rdata", rd, 32'hDEADBEEF);
    chk("rd_err", 32'(er), 32'h0);
    chk("rd_read_enable_issue", 32'(rei), 32'h1);

    // Port 0 waits behind a stalled port 1 response.
    set_req(0, 1, 0, 32'h10, 32'h0);
    txn(1, 0, 32'h10, 32'h0, 5, rd, er, lat, rei);
    chk("stall_rdata", rd, 32'hDEADBEEF);
    @(negedge clk);
    chk("stall_p0_accept_next", 32'(bus.req0_ready), 32'h1);
    @(posedge clk); #1;
    set_req(0, 0, 0, '0, '0);
    bus.rsp0_ready = 1;
    n = 0;
    @(negedge clk);
    while (!bus.rsp0_valid && n < 40) begin @(negedge clk); n++; end
    if (!bus.rsp0_valid) fail_now("stall_p0_rsp");
    else chk("stall_p0_rdata", bus.rsp_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    bus.rsp0_ready = 0;

    // Reset during the memory-access cycle of a write.
    set_req(0, 1, 1, 32'h20, 32'h12345678);
    n = 0;
    @(negedge clk);
    while (!bus.req0_ready && n < 40) begin @(negedge clk); n++; end
    if (!bus.req0_ready) fail_now("rst_issue_accept");
    @(posedge clk); #1;
    set_req(0, 0, 0, '0, '0);
    rst_n = 0;
    @(negedge clk);
    chk("rst_issue_write_enable", 32'(bus.write_enable), 32'h0);
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("rst_after_rsp0_valid", 32'(bus.rsp0_valid), 32'h0);
    chk("rst_after_read_enable", 32'(bus.read_enable), 32'h0);
    chk("rst_after_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_after_mem_wdata", bus.mem_write_data, 32'h0);
    chk("rst_after_rsp_rdata", bus.rsp_rdata, 32'h0);
    @(posedge clk); #1;
    txn(0, 0, 32'h20, 32'h0, 0, rd, er, lat, rei);
    chk("rst_no_commit", rd, 32'h0);

    // Both ports saturated right after reset.
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    grant_log.delete();
    bus.rsp0_ready = 1;
    bus.rsp1_ready = 1;
    for (int i = 0; i < 30; i++) begin
      set_req(0, 1, 0, rand_addr(), '0);
      set_req(1, 1, 0, rand_addr(), '0);
      @(negedge clk);
      chk("fair_both_ready", 32'(bus.req0_ready && bus.req1_ready), 32'h0);
      @(posedge clk); #1;
    end
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    repeat (4) @(posedge clk);
    #1;
    bus.rsp0_ready = 0;
    bus.rsp1_ready = 0;
    chk("fair_count", 32'(grant_log.size()), 32'd10);
    for (int i = 0; i < grant_log.size() && i < 4; i++)
      chk("fair_order", 32'(grant_log[i]), 32'(i % 2));
    for (int i = 1; i < grant_log.size(); i++)
      chk("fair_alternate", 32'(grant_log[i] != grant_log[i-1]), 32'h1);

    // Address 0x400 aliases word 0 unless the range check is built in.
    txn(1, 1, 32'h400, 32'hCAFEF00D, 0, rd, er, lat, rei);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    chk("alias_wr_err", 32'(er), 32'h1);
`else
    chk("alias_wr_err", 32'(er), 32'h0);
`endif
    txn(1, 0, 32'h0, 32'h0, 0, rd, er, lat, rei);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    chk("alias_rd_rdata", rd, 32'h0);
    txn(0, 0, 32'h6, 32'h0, 0, rd, er, lat, rei);
    chk("misalign_err", 32'(er), 32'h1);
    chk("misalign_rdata", rd, 32'h0);
    chk("misalign_read_enable", 32'(rei), 32'h0);
`else
    chk("alias_rd_rdata", rd, 32'hCAFEF00D);
`endif

    for (int i = 0; i < 800; i++) begin
      set_req(0, 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      set_req(1, 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      bus.rsp0_ready = 1'($urandom_range(0, 1));
      bus.rsp1_ready = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 99) != 0);
      @(posedge clk); #1;
    end
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port word data memory between two requesters: port 0 (core load/store unit) and port 1 (DMA/debug loader).
- Valid/ready request and response handshakes per port; round-robin arbitration; one outstanding transaction at a time.
- Drives the memory's write_enable/read_enable/mem_addr/mem_write_data.
- Captures the memory's combinational read data into a held response register.

Parameters:
- DATA_W, 32, data and address width.
- DEPTH_WORDS, 256, memory depth in words; used only by the optional range check.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- reqN_valid  in  1  (N=0,1) request valid.
- reqN_ready  out  1  request accepted this cycle when high with reqN_valid.
- reqN_we  in  1  1 = write, 0 = read.
- reqN_addr  in  DATA_W  byte address.
- reqN_wdata  in  DATA_W  write data.
- rspN_valid  out  1  response for port N available.
- rspN_ready  in  1  port N consumes the response.
- rsp_rdata  out  DATA_W  read data, shared by both ports, qualified by rspN_valid; 0 for writes.
- rsp_err  out  1  error flag, shared, qualified by rspN_valid.
- write_enable  out  1  to memory.
- read_enable  out  1  to memory.
- mem_addr  out  DATA_W  to memory; word index taken from bits [9:2].
- mem_write_data  out  DATA_W  to memory.
- mem_read_data  in  DATA_W  from memory, combinational read.

Behaviour:
- Clocking: single clock clk; all state updates on the rising edge. rst_n is synchronous, active-low.
- Reset values:
  - state=IDLE, last_grant=1 (so port 0 wins the first tie).
  - All command and response registers are 0.
  - rspN_valid=0, rsp_rdata=0, rsp_err=0.
  - write_enable=0, read_enable=0, mem_addr=0, mem_write_data=0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - grant = the only valid port; if both are valid, grant = !last_grant.
  - reqN_ready = (state==IDLE) && grant==N && reqN_valid. Ready depends on valid.
  - On handshake: register we/addr/wdata and owner; set last_grant=owner; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_addr = registered address; mem_write_data = registered wdata.
  - write_enable = we && rst_n; read_enable = !we.
  - At the clock edge: rsp_rdata <= we ? 0 : mem_read_data; rsp_err <= 0. The memory commits the write on the same edge.
  - Next state is RESP.
- RESP:
  - rsp{owner}_valid=1; rsp_rdata and rsp_err are held stable until rsp{owner}_ready.
  - On handshake go to IDLE. Both reqN_ready stay 0.
  - The other port's rsp_valid stays 0 and its rsp_ready is ignored.
- Memory outputs outside ISSUE: write_enable=0 and read_enable=0; mem_addr and mem_write_data hold their last value.
- Latency and throughput:
  - Accept at cycle T → memory access in T+1 → rsp_valid from T+2.
  - Earliest next accept is the cycle after the response handshake. Peak rate is 1 transaction per 3 cycles.
- Fairness: under continuous requests from both ports, grants alternate strictly 0,1,0,1…
- A requester may drop reqN_valid without handshake; nothing is recorded.
- reqN_* inputs are sampled only at the handshake edge; later changes have no effect.
- Reset mid-operation:
  - rst_n low in ISSUE: write_enable is forced 0, so no write is committed; the FSM returns to IDLE.
  - rst_n low in RESP: the pending response is discarded and rspN_valid=0 next cycle.
- No address wrap-around logic beyond the memory's own bits [9:2] truncation, unless the optional feature is enabled.

Optional Feature:
- Macro: DMEM_ARB_ALIGN_CHECK_EN.
- Defined — in ISSUE, an access is illegal if either holds:
  - addr[1:0] != 0, or
  - addr >> 2 >= DEPTH_WORDS.
- For an illegal access:
  - write_enable=0 and read_enable=0.
  - rsp_err <= 1, rsp_rdata <= 0.
  - Timing and FSM are unchanged.
- Not defined: no check; rsp_err is constant 0; addresses alias via bits [9:2].

Test Plan:
- Reset, then port 0 write 0xDEADBEEF to 0x10 and read back 0x10:
  - each response has rsp0_valid 2 cycles after accept;
  - read rsp_rdata=0xDEADBEEF; write rsp_rdata=0; rsp_err=0.
- Both ports continuously request reads after reset:
  - grant order 0,1,0,1;
  - reqN_ready never high for both ports in the same cycle;
  - each response goes to the correct port.
- Port 1 read with rsp1_ready held low for 5 cycles:
  - rsp1_valid and rsp_rdata stay stable;
  - req0_ready stays 0 throughout;
  - port 0 is accepted the cycle after rsp1_ready rises.
- Port 0 write 0x12345678 to 0x20, with rst_n low in the ISSUE cycle:
  - no write is committed (later read of 0x20 returns the prior value 0);
  - all outputs are at reset values the next cycle.
- Port 1 write to 0x400 then read 0x000:
  - without the macro, aliasing returns the written value;
  - with DMEM_ARB_ALIGN_CHECK_EN, the write has rsp_err=1 and is not performed, and the read returns 0.
- With DMEM_ARB_ALIGN_CHECK_EN, port 0 read of 0x06:
  - rsp_err=1, rsp_rdata=0;
  - read_enable stays 0 in the ISSUE cycle.
